mmio_fifo_port: RTL

MMIO_FIFO_PORT -- requirements
Module: mmio_fifo_port

---
 rtl/mmio_fifo_pkg.sv | 44 ++++
 rtl/mmio_fifo_port_sync_fifo.sv | 87 ++++++++
 rtl/mmio_fifo_port.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_fifo_pkg.sv
// mmio_fifo_pkg: shared constants and types for mmio_fifo_port.
//   The register map is decoded from addr[3:2]. This package also holds the
//   STATUS/CTRL bit positions and the packed STATUS word layout.
package mmio_fifo_pkg;

    // Register indices, taken from addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_TX_FLUSH    = 1;
    localparam int unsigned CTRL_RX_FLUSH    = 2;
    localparam int unsigned CTRL_ERR_CLR     = 3;
    localparam int unsigned CTRL_TX_EMPTY_IE = 4;
    localparam int unsigned CTRL_RX_AVAIL_IE = 5;

    // STATUS bit positions
    localparam int unsigned STAT_TX_FULL      = 0;
    localparam int unsigned STAT_TX_EMPTY     = 1;
    localparam int unsigned STAT_RX_FULL      = 2;
    localparam int unsigned STAT_RX_EMPTY     = 3;
    localparam int unsigned STAT_TX_OVF       = 4;
    localparam int unsigned STAT_RX_UDF       = 5;
    localparam int unsigned STAT_TX_LEVEL_LSB = 8;
    localparam int unsigned STAT_RX_LEVEL_LSB = 16;

    // STATUS word, MSB first; reserved fields read 0
    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] rx_level;
        logic [7:0] tx_level;
        logic [1:0] rsvd_lo;
        logic       rx_udf;
        logic       tx_ovf;
        logic       rx_empty;
        logic       rx_full;
        logic       tx_empty;
        logic       tx_full;
    } status_t;

endpackage

// File: rtl/mmio_fifo_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush. It is used for both the TX and RX paths.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write one word (ignored when full or flushing)
//   pop, head_c     : drop the head word; head_c is the current head (combinational)
//   flush           : empty the FIFO in one cycle; it overrides push and pop
//   full, empty     : registered flags
//   level           : registered occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_c,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Pointer/level update; DEPTH is a power of two, so pointers wrap naturally
    always_comb begin
        do_push  = push && !full_q && !flush;
        do_pop   = pop && !empty_q && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Storage write
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;
    assign level  = level_q;

endmodule

// File: rtl/mmio_fifo_port.sv
// mmio_fifo_port: MMIO register front-end. It connects to a TX stream FIFO and an RX stream FIFO.
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en/addr/data/byteen   : MMIO write port (TXDATA push, CTRL)
//   rd_en/addr, rd_data      : MMIO read port; rd_data is registered and held
//   m_tdata/tvalid/tready    : TX stream out (head of the TX FIFO)
//   s_tdata/tvalid/tready    : RX stream in
//   irq                      : present only when MMIO_FIFO_IRQ_EN is defined
// Optional feature macro: MMIO_FIFO_IRQ_EN (interrupt output and CTRL[5:4] enables).
module mmio_fifo_port #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byteen,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready
`ifdef MMIO_FIFO_IRQ_EN
    ,
    output logic                    irq
`endif
);

    import mmio_fifo_pkg::*;

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            wr_idx, rd_idx;
    logic                  ctrl_wr, tx_flush, rx_flush, err_clr;
    logic                  tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic                  rx_pop_req, rx_pop, rx_push, rx_udf_set;
    logic [DATA_WIDTH-1:0] tx_wdata, tx_head, rx_head, ctrl_rd;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [LW-1:0]         tx_level, rx_level;
    status_t               status;

    logic                  en_q, en_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  rx_udf_q, rx_udf_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
`ifdef MMIO_FIFO_IRQ_EN
    logic                  tx_empty_ie_q, tx_empty_ie_d;
    logic                  rx_avail_ie_q, rx_avail_ie_d;
    logic                  irq_q, irq_d;
`endif

    // Only addr[3:2] selects a register
    logic unused_addr;
    assign unused_addr = ^{wr_addr[ADDR_WIDTH-1:4], wr_addr[1:0],
                           rd_addr[ADDR_WIDTH-1:4], rd_addr[1:0]};
    assign wr_idx = wr_addr[3:2];
    assign rd_idx = rd_addr[3:2];

    // Decode, FIFO control, sticky errors and read mux
    always_comb begin
        ctrl_wr  = wr_en && (wr_idx == REG_CTRL) && wr_byteen[0];
        tx_flush = ctrl_wr && wr_data[CTRL_TX_FLUSH];
        rx_flush = ctrl_wr && wr_data[CTRL_RX_FLUSH];
        err_clr  = ctrl_wr && wr_data[CTRL_ERR_CLR];

        // The full check uses the start-of-cycle state; a pop in this cycle cannot free room.
        tx_push_req = wr_en && (wr_idx == REG_TXDATA) && (|wr_byteen);
        tx_push     = tx_push_req && !tx_full;
        tx_ovf_set  = tx_push_req && tx_full && !tx_flush;
        tx_pop      = m_tvalid && m_tready;

        rx_pop_req = rd_en && (rd_idx == REG_RXDATA);
        rx_pop     = rx_pop_req && !rx_empty;
        rx_udf_set = rx_pop_req && rx_empty;
        rx_push    = s_tvalid && s_tready;

        for (int unsigned i = 0; i < NB; i++) begin
            tx_wdata[i*8 +: 8] = wr_byteen[i] ? wr_data[i*8 +: 8] : 8'h00;
        end

        en_d     = ctrl_wr ? wr_data[CTRL_EN] : en_q;
        // A same-cycle set overrides the clear
        tx_ovf_d = (tx_ovf_q && !err_clr) || tx_ovf_set;
        rx_udf_d = (rx_udf_q && !err_clr) || rx_udf_set;

        status          = '0;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
        status.rx_full  = rx_full;
        status.rx_empty = rx_empty;
        status.tx_ovf   = tx_ovf_q;
        status.rx_udf   = rx_udf_q;
        status.tx_level = 8'(tx_level);
        status.rx_level = 8'(rx_level);

        ctrl_rd          = '0;
        ctrl_rd[CTRL_EN] = en_q;
`ifdef MMIO_FIFO_IRQ_EN
        ctrl_rd[CTRL_TX_EMPTY_IE] = tx_empty_ie_q;
        ctrl_rd[CTRL_RX_AVAIL_IE] = rx_avail_ie_q;
        tx_empty_ie_d = ctrl_wr ? wr_data[CTRL_TX_EMPTY_IE] : tx_empty_ie_q;
        rx_avail_ie_d = ctrl_wr ? wr_data[CTRL_RX_AVAIL_IE] : rx_avail_ie_q;
        irq_d = (tx_empty && tx_empty_ie_q) || (!rx_empty && rx_avail_ie_q)
                || tx_ovf_q || rx_udf_q;
`endif

        // rd_data holds its value between reads
        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (rd_idx)
                REG_TXDATA: rd_data_d = '0;
                REG_RXDATA: rd_data_d = rx_empty ? '0 : rx_head;
                REG_STATUS: rd_data_d = DATA_WIDTH'(status);
                REG_CTRL:   rd_data_d = ctrl_rd;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
            rd_data_q <= '0;
`ifdef MMIO_FIFO_IRQ_EN
            tx_empty_ie_q <= 1'b0;
            rx_avail_ie_q <= 1'b0;
            irq_q         <= 1'b0;
`endif
        end else begin
            en_q      <= en_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_udf_q  <= rx_udf_d;
            rd_data_q <= rd_data_d;
`ifdef MMIO_FIFO_IRQ_EN
            tx_empty_ie_q <= tx_empty_ie_d;
            rx_avail_ie_q <= rx_avail_ie_d;
            irq_q         <= irq_d;
`endif
        end
    end

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_wdata),
        .pop       (tx_pop),
        .head_c    (tx_head),
        .flush     (tx_flush),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (s_tdata),
        .pop       (rx_pop),
        .head_c    (rx_head),
        .flush     (rx_flush),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign rd_data  = rd_data_q;
    assign m_tdata  = tx_head;
    assign m_tvalid = en_q && !tx_empty;
    assign s_tready = en_q && !rx_full;
`ifdef MMIO_FIFO_IRQ_EN
    assign irq = irq_q;
`endif

endmodule
